iq_issue_scheduler: RTL and testbench

Wakeup/select controller for the out-of-order instruction queue. It allocates queue slots to renamed instructions and tracks source-operand readiness per slot from physical-register writeback broadcasts. Each cycle it selects the oldest fully-ready slot into a registered issue port. The payload RAM stays in the queue datapath and is indexed by `alloc_idx` and `issue_idx`; this block owns only occupancy, readiness, age and the flush squash.

---
 rtl/iq_issue_scheduler.sv | 174 +++++++++++++++++
 tb/tb_iq_issue_scheduler.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_issue_scheduler.sv
// Purpose: instruction-queue wakeup/select control (occupancy, operand readiness, age, flush squash).
// Latency: a slot ready at cycle t is selected in t and shows on the issue register at t+1.
// Backpressure: alloc_ready drops when full, flushing or in reset; issue register holds while !issue_ready.
module iq_issue_scheduler #(
  parameter int ENTRIES = 32,
  parameter int PREGS   = 64,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = $clog2(PREGS),
  parameter int AGE_W   = IDX_W + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic [TAG_W-1:0] alloc_src1_tag,
  input  logic [TAG_W-1:0] alloc_src2_tag,
  input  logic             alloc_src1_rdy,
  input  logic             alloc_src2_rdy,
  output logic [IDX_W-1:0] alloc_idx,
  output logic [AGE_W-1:0] alloc_age,
  input  logic             wb0_valid,
  input  logic [TAG_W-1:0] wb0_tag,
  input  logic             wb1_valid,
  input  logic [TAG_W-1:0] wb1_tag,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [IDX_W-1:0] issue_idx,
  output logic [AGE_W-1:0] issue_age,
  input  logic             flush_valid,
  input  logic [AGE_W-1:0] flush_age,
  output logic [IDX_W:0]   count
);

  // Per-slot state
  logic [ENTRIES-1:0] occ;
  logic [ENTRIES-1:0] s1_rdy;
  logic [ENTRIES-1:0] s2_rdy;
  logic [TAG_W-1:0]   s1_tag [ENTRIES];
  logic [TAG_W-1:0]   s2_tag [ENTRIES];
  logic [AGE_W-1:0]   age    [ENTRIES];
  logic [AGE_W-1:0]   seq;

  // Per-cycle decode
  logic [ENTRIES-1:0] wk1;
  logic [ENTRIES-1:0] wk2;
  logic [ENTRIES-1:0] squash;
  logic [ENTRIES-1:0] cand;
  logic [ENTRIES-1:0] occ_next;
  logic [IDX_W:0]     squash_cnt;
  logic [IDX_W:0]     count_next;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [AGE_W-1:0]   sel_age;
  logic               alloc_fire;
  logic               alloc_s1_rdy;
  logic               alloc_s2_rdy;
  logic               issue_squash;
  logic               issue_load;
  logic               sel_fire;

  // Modular age compare: a is older than b when (a-b) has its top bit set.
  function automatic logic older(input logic [AGE_W-1:0] a, input logic [AGE_W-1:0] b);
    logic [AGE_W-1:0] d;
    d = a - b;
    return d[AGE_W-1];
  endfunction

  assign alloc_ready = !rst && !flush_valid && (count < (IDX_W+1)'(ENTRIES));
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_age   = seq;

  // Same-cycle writeback bypass for the incoming instruction's sources
  assign alloc_s1_rdy = alloc_src1_rdy || (wb0_valid && (alloc_src1_tag == wb0_tag))
                                       || (wb1_valid && (alloc_src1_tag == wb1_tag));
  assign alloc_s2_rdy = alloc_src2_rdy || (wb0_valid && (alloc_src2_tag == wb0_tag))
                                       || (wb1_valid && (alloc_src2_tag == wb1_tag));

  // A flush squashes the issue register when its entry is younger than flush_age;
  // in that cycle the register simply empties and no new select happens.
  assign issue_squash = flush_valid && issue_valid && older(flush_age, issue_age);
  assign issue_load   = (!issue_valid || issue_ready) && !issue_squash;
  assign sel_fire     = issue_load && sel_found;

  // Lowest-numbered free slot, from start-of-cycle occupancy
  always_comb begin
    alloc_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!occ[i]) alloc_idx = IDX_W'(i);
    end
  end

  // Wakeup matches, flush squash mask and select candidates (ready bits before this cycle's wakeups)
  always_comb begin
    wk1        = '0;
    wk2        = '0;
    squash     = '0;
    cand       = '0;
    squash_cnt = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      wk1[i]     = (wb0_valid && (s1_tag[i] == wb0_tag)) || (wb1_valid && (s1_tag[i] == wb1_tag));
      wk2[i]     = (wb0_valid && (s2_tag[i] == wb0_tag)) || (wb1_valid && (s2_tag[i] == wb1_tag));
      squash[i]  = flush_valid && occ[i] && older(flush_age, age[i]);
      cand[i]    = occ[i] && s1_rdy[i] && s2_rdy[i] && !squash[i];
      squash_cnt = squash_cnt + (IDX_W+1)'(squash[i]);
    end
  end

  // Oldest-ready select across all candidate slots
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (cand[i] && (!sel_found || older(age[i], sel_age))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = age[i];
      end
    end
  end

  // Next occupancy and occupancy count
  always_comb begin
    occ_next = occ;
    for (int i = 0; i < ENTRIES; i++) begin
      if (squash[i] || (sel_fire && (sel_idx == IDX_W'(i)))) occ_next[i] = 1'b0;
      if (alloc_fire && (alloc_idx == IDX_W'(i)))            occ_next[i] = 1'b1;
    end
    count_next = count + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(sel_fire) - squash_cnt;
  end

  // Control state: occupancy, sequence counter, issue register, count
  always_ff @(posedge clk) begin
    if (rst) begin
      occ         <= '0;
      seq         <= '0;
      count       <= '0;
      issue_valid <= 1'b0;
      issue_idx   <= '0;
      issue_age   <= '0;
    end else begin
      occ   <= occ_next;
      count <= count_next;
      if (flush_valid)     seq <= flush_age + AGE_W'(1);
      else if (alloc_fire) seq <= seq + AGE_W'(1);
      if (issue_squash) begin
        issue_valid <= 1'b0;
      end else if (issue_load) begin
        issue_valid <= sel_found;
        if (sel_found) begin
          issue_idx <= sel_idx;
          issue_age <= sel_age;
        end
      end
    end
  end

  // Slot payload: tags, ready bits and age; only meaningful while occ is set
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (alloc_fire && (alloc_idx == IDX_W'(i))) begin
        s1_tag[i] <= alloc_src1_tag;
        s2_tag[i] <= alloc_src2_tag;
        s1_rdy[i] <= alloc_s1_rdy;
        s2_rdy[i] <= alloc_s2_rdy;
        age[i]    <= seq;
      end else begin
        if (wk1[i]) s1_rdy[i] <= 1'b1;
        if (wk2[i]) s2_rdy[i] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_iq_issue_scheduler.sv
// Purpose: scoreboard bench for iq_issue_scheduler; expected issues queued at stimulus, popped on handshake.
// Latency: inputs change 1 time unit after posedge; monitor samples on negedge.
// Backpressure: issue_ready driven per scenario to exercise hold and full conditions.
module tb_iq_issue_scheduler;
  localparam int ENTRIES = 32;
  localparam int PREGS   = 64;
  localparam int IDX_W   = 5;
  localparam int TAG_W   = 6;
  localparam int AGE_W   = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             alloc_valid = 1'b0;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_src1_tag = '0;
  logic [TAG_W-1:0] alloc_src2_tag = '0;
  logic             alloc_src1_rdy = 1'b0;
  logic             alloc_src2_rdy = 1'b0;
  logic [IDX_W-1:0] alloc_idx;
  logic [AGE_W-1:0] alloc_age;
  logic             wb0_valid = 1'b0;
  logic [TAG_W-1:0] wb0_tag = '0;
  logic             wb1_valid = 1'b0;
  logic [TAG_W-1:0] wb1_tag = '0;
  logic             issue_valid;
  logic             issue_ready = 1'b0;
  logic [IDX_W-1:0] issue_idx;
  logic [AGE_W-1:0] issue_age;
  logic             flush_valid = 1'b0;
  logic [AGE_W-1:0] flush_age = '0;
  logic [IDX_W:0]   count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_idx_q[$];
  int exp_age_q[$];
  int mon_idx;
  int mon_age;

  iq_issue_scheduler #(.ENTRIES(ENTRIES), .PREGS(PREGS)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_src1_tag(alloc_src1_tag), .alloc_src2_tag(alloc_src2_tag),
    .alloc_src1_rdy(alloc_src1_rdy), .alloc_src2_rdy(alloc_src2_rdy),
    .alloc_idx(alloc_idx), .alloc_age(alloc_age),
    .wb0_valid(wb0_valid), .wb0_tag(wb0_tag),
    .wb1_valid(wb1_valid), .wb1_tag(wb1_tag),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_idx(issue_idx), .issue_age(issue_age),
    .flush_valid(flush_valid), .flush_age(flush_age),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int idx, input int age);
    exp_idx_q.push_back(idx);
    exp_age_q.push_back(age);
  endtask

  // Scoreboard monitor: every accepted issue must match the next queued expectation
  always @(negedge clk) begin
    if (!rst && issue_valid && issue_ready) begin
      if (exp_idx_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_issue: got idx %0d age %0d, expected no issue", issue_idx, issue_age);
      end else begin
        mon_idx = exp_idx_q.pop_front();
        mon_age = exp_age_q.pop_front();
        check("sb_issue_idx", int'(issue_idx), mon_idx);
        check("sb_issue_age", int'(issue_age), mon_age);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    check("leftover_expectations", exp_idx_q.size(), 0);
    exp_idx_q.delete();
    exp_age_q.delete();
    rst = 1'b1; alloc_valid = 1'b0; wb0_valid = 1'b0; wb1_valid = 1'b0;
    flush_valid = 1'b0; issue_ready = 1'b0;
    step();
    step();
    check("rst_issue_valid", int'(issue_valid), 0);
    check("rst_issue_idx", int'(issue_idx), 0);
    check("rst_issue_age", int'(issue_age), 0);
    check("rst_count", int'(count), 0);
    check("rst_alloc_ready", int'(alloc_ready), 0);
    rst = 1'b0;
    #1;
    check("post_rst_alloc_ready", int'(alloc_ready), 1);
    check("post_rst_alloc_age", int'(alloc_age), 0);
  endtask

  task automatic alloc(input int t1, input bit r1, input int t2, input bit r2,
                       input int e_idx, input int e_age);
    alloc_src1_tag = TAG_W'(t1);
    alloc_src1_rdy = r1;
    alloc_src2_tag = TAG_W'(t2);
    alloc_src2_rdy = r2;
    alloc_valid    = 1'b1;
    #1;
    check("alloc_ready", int'(alloc_ready), 1);
    check("alloc_idx", int'(alloc_idx), e_idx);
    check("alloc_age", int'(alloc_age), e_age);
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic wait_issue(input string name, input int budget);
    int k;
    k = 0;
    while (!issue_valid && k < budget) begin
      step();
      k++;
    end
    check(name, int'(issue_valid), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic issue
    do_reset();
    issue_ready = 1'b1;
    push_exp(0, 0);
    alloc(1, 1, 2, 1, 0, 0);
    wait_issue("basic_issue_valid", 3);
    check("basic_issue_idx", int'(issue_idx), 0);
    check("basic_count", int'(count), 0);
    step();
    check("basic_drained", int'(issue_valid), 0);

    // Oldest-first: tags 5,6,7; wake 7 and 5 together
    do_reset();
    issue_ready = 1'b1;
    alloc(5, 0, 0, 1, 0, 0);
    alloc(6, 0, 0, 1, 1, 1);
    alloc(7, 0, 0, 1, 2, 2);
    push_exp(0, 0);
    push_exp(2, 2);
    wb0_valid = 1'b1; wb0_tag = 6'd7; wb1_valid = 1'b1; wb1_tag = 6'd5;
    step();
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    check("oldest_wake_plus1", int'(issue_valid), 0);
    step();
    check("oldest_wake_plus2_valid", int'(issue_valid), 1);
    check("oldest_first_idx", int'(issue_idx), 0);
    step();
    check("oldest_second_idx", int'(issue_idx), 2);
    step();
    check("oldest_drained", int'(issue_valid), 0);
    check("oldest_count", int'(count), 1);

    // Same-cycle bypass
    do_reset();
    issue_ready = 1'b1;
    push_exp(0, 0);
    wb0_valid = 1'b1; wb0_tag = 6'd9;
    alloc(9, 0, 3, 1, 0, 0);
    wb0_valid = 1'b0;
    wait_issue("bypass_issue_valid", 3);
    check("bypass_count", int'(count), 0);
    step();
    check("bypass_drained", int'(issue_valid), 0);

    // Full and backpressure
    do_reset();
    issue_ready = 1'b0;
    for (int i = 0; i < ENTRIES; i++) alloc(i + 1, 0, 0, 1, i, i);
    check("full_count", int'(count), 32);
    check("full_alloc_ready", int'(alloc_ready), 0);
    wb0_valid = 1'b1; wb0_tag = 6'd20;
    step();
    wb0_valid = 1'b0;
    #1;
    check("full_select_cycle_alloc_ready", int'(alloc_ready), 0);
    check("full_select_cycle_count", int'(count), 32);
    step();
    check("full_issue_valid", int'(issue_valid), 1);
    check("full_issue_idx", int'(issue_idx), 19);
    check("full_issue_age", int'(issue_age), 19);
    check("full_count_after_select", int'(count), 31);
    check("full_alloc_ready_after", int'(alloc_ready), 1);
    push_exp(19, 19);
    for (int k = 0; k < 5; k++) begin
      step();
      check("hold_valid", int'(issue_valid), 1);
      check("hold_idx", int'(issue_idx), 19);
    end
    issue_ready = 1'b1;
    step();
    check("hold_released", int'(issue_valid), 0);
    check("hold_count", int'(count), 31);

    // Flush: ages 0..9, age 8 in issue register, flush_age 4
    do_reset();
    issue_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 8) alloc(40, 1, 41, 1, 8, 8);
      else        alloc(i + 1, 0, 0, 1, i, i);
    end
    check("preflush_issue_valid", int'(issue_valid), 1);
    check("preflush_issue_age", int'(issue_age), 8);
    check("preflush_count", int'(count), 9);
    flush_valid = 1'b1; flush_age = 7'd4;
    #1;
    check("flush_alloc_ready", int'(alloc_ready), 0);
    step();
    flush_valid = 1'b0;
    #1;
    check("flush_issue_valid", int'(issue_valid), 0);
    check("flush_count", int'(count), 5);
    check("flush_next_age", int'(alloc_age), 5);
    check("flush_next_idx", int'(alloc_idx), 5);
    issue_ready = 1'b1;
    push_exp(4, 4);
    wb0_valid = 1'b1; wb0_tag = 6'd5; wb1_valid = 1'b1; wb1_tag = 6'd7;
    step();
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    step();
    check("survivor_issue_idx", int'(issue_idx), 4);
    step();
    check("squashed_not_issued", int'(issue_valid), 0);
    check("survivor_count", int'(count), 4);

    // Reset with an issue pending
    issue_ready = 1'b0;
    alloc(40, 1, 41, 1, 4, 5);
    wait_issue("pending_issue_valid", 3);
    check("pending_issue_idx", int'(issue_idx), 4);
    rst = 1'b1;
    step();
    check("midrst_issue_valid", int'(issue_valid), 0);
    check("midrst_count", int'(count), 0);
    check("midrst_alloc_ready", int'(alloc_ready), 0);

    // Wrap-around of the sequence number
    do_reset();
    issue_ready = 1'b1;
    for (int n = 0; n < 382; n++) begin
      push_exp(0, n % 128);
      alloc(3, 1, 4, 1, 0, n % 128);
      step();
      step();
    end
    alloc(10, 0, 4, 1, 0, 126);
    push_exp(1, 127);
    alloc(3, 1, 4, 1, 1, 127);
    step();
    step();
    push_exp(1, 0);
    alloc(3, 1, 4, 1, 1, 0);
    step();
    step();
    alloc(11, 0, 4, 1, 1, 1);
    push_exp(0, 126);
    push_exp(1, 1);
    wb0_valid = 1'b1; wb0_tag = 6'd11; wb1_valid = 1'b1; wb1_tag = 6'd10;
    step();
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    step();
    check("wrap_first_age", int'(issue_age), 126);
    step();
    check("wrap_second_age", int'(issue_age), 1);
    step();
    check("wrap_drained", int'(issue_valid), 0);
    check("wrap_count", int'(count), 0);

    check("final_expectations_left", exp_idx_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
